// File: rtl/reg_access_arbiter_pkg.sv
// Shared definitions for the register-access arbiter: FSM state encodings and default widths.
package reg_access_arbiter_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 16;
  localparam int AW_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/reg_access_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  int   cand;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that runs one register-bank access at a time (IDLE -> ACCESS -> RESP)
// and returns read data or a zero write-ack to the winning requester.
module reg_access_arbiter
  import reg_access_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_rdata,
  output logic [(2**AW)-1:0]   reg_sel,
  output logic                 reg_wr,
  output logic [DW-1:0]        reg_wdata,
  input  logic [DW-1:0]        reg_rdata,
  output logic [1:0]           dbg_state
);
  localparam int NREG = 2 ** AW;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a request is accepted on the rising edge where req_valid[i] and
  // req_ready[i] are both high; ready only rises in IDLE and for one requester.
  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic [AW-1:0]   sel_addr;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      reg_sel   <= '0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= ACCESS;
            win       <= gnt_idx;
            ptr       <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            reg_sel   <= NREG'(1) << sel_addr;
            reg_wr    <= req_wr[gnt_idx];
            reg_wdata <= req_wdata[gnt_idx*DW +: DW];
          end
        end
        ACCESS: begin
          // The bank captures writes on this edge; reads are sampled from the OR bus.
          state     <= RESP;
          rsp_rdata <= reg_wr ? '0 : reg_rdata;
          rsp_valid <= NREQ'(1) << win;
          reg_sel   <= '0;
          reg_wr    <= 1'b0;
          reg_wdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: behavioural register bank, round-robin reference model, scenario tasks.
module tb_reg_access_arbiter;
  import reg_access_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int AW   = 2;
  localparam int NREG = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid, req_ready, req_wr, rsp_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [DW-1:0]       rsp_rdata, reg_wdata, reg_rdata;
  logic [NREG-1:0]     reg_sel;
  logic                reg_wr;
  logic [1:0]          dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] model_mem [NREG];
  int            model_ptr;
  logic [DW-1:0] exp_q [$];
  int            obs_q [$];

  // Clock / reset
  always #5 clk = ~clk;

  reg_access_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .reg_sel   (reg_sel),
    .reg_wr    (reg_wr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .dbg_state (dbg_state)
  );

  // Register bank: flop per register, write on sel&wr, read drives data on sel&~wr, all ORed.
  logic [DW-1:0] bank [NREG];
  logic          bank_clr;

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bank_clr) bank[i] <= '0;
      else if (reg_sel[i] && reg_wr) bank[i] <= reg_wdata;
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (reg_sel[i] && !reg_wr) reg_rdata = reg_rdata | bank[i];
  end

  // Reference: first pending requester at or above ptr, wrapping.
  function automatic int pick_winner(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Driver tasks
  task automatic set_op(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i]             = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    @(posedge clk); #1;
  endtask

  // Serves up to n grants from the requesters in mask. Call at posedge+1 of an IDLE cycle;
  // returns at posedge+1 of the following IDLE cycle with req_valid cleared.
  task automatic run_grants(input logic [NREQ-1:0] mask, input int n, input bit keep, input bit rnd);
    logic [NREQ-1:0] pend;
    logic            wr;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d, exp_rd;
    int              w, obs, got;
    pend = mask;
    got  = 0;
    if (rnd) for (int i = 0; i < NREQ; i++) if (mask[i]) rand_op(i);
    req_valid = pend;
    while (got < n && pend != '0) begin
      @(negedge clk);
      w   = pick_winner(pend, model_ptr);
      obs = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs = i;
      obs_q.push_back(obs);
      n_cmp++;
      if (req_ready !== NREQ'(1 << w)) begin
        n_bad++;
        $display("FAIL grant: req_ready=%b expected %b (pend=%b ptr=%0d)", req_ready, NREQ'(1 << w), pend, model_ptr);
      end
      wr = req_wr[w];
      a  = req_addr[w*AW +: AW];
      d  = req_wdata[w*DW +: DW];
      exp_q.push_back(wr ? '0 : model_mem[a]);
      if (wr) model_mem[a] = d;
      model_ptr = (w + 1) % NREQ;
      @(posedge clk); #1;
      if (keep) rand_op(w);
      else pend[w] = 1'b0;
      req_valid = pend;
      @(negedge clk);
      n_cmp++;
      if (reg_sel !== NREG'(1 << a) || reg_wr !== wr || reg_wdata !== d) begin
        n_bad++;
        $display("FAIL access: sel=%b wr=%b wdata=%h expected %b %b %h", reg_sel, reg_wr, reg_wdata, NREG'(1 << a), wr, d);
      end
      n_cmp++;
      if (req_ready !== '0 || rsp_valid !== '0 || dbg_state !== ACCESS) begin
        n_bad++;
        $display("FAIL access_quiet: ready=%b rsp_valid=%b state=%0d expected 0 0 %0d", req_ready, rsp_valid, dbg_state, ACCESS);
      end
      @(negedge clk);
      exp_rd = exp_q.pop_front();
      n_cmp++;
      if (rsp_valid !== NREQ'(1 << w) || rsp_rdata !== exp_rd) begin
        n_bad++;
        $display("FAIL resp: rsp_valid=%b rdata=%h expected %b %h", rsp_valid, rsp_rdata, NREQ'(1 << w), exp_rd);
      end
      n_cmp++;
      if (reg_sel !== '0 || reg_wr !== 1'b0 || req_ready !== '0) begin
        n_bad++;
        $display("FAIL resp_quiet: sel=%b wr=%b ready=%b expected all 0", reg_sel, reg_wr, req_ready);
      end
      got++;
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst       = 1'b1;
    bank_clr  = 1'b1;
    req_valid = '1;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NREG; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (req_ready !== '0 || rsp_valid !== '0 || reg_sel !== '0 || reg_wr !== 1'b0 ||
        reg_wdata !== '0 || rsp_rdata !== '0 || dbg_state !== IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b rsp=%b sel=%b wr=%b wdata=%h rdata=%h state=%0d expected all 0",
               req_ready, rsp_valid, reg_sel, reg_wr, reg_wdata, rsp_rdata, dbg_state);
    end
    bank_clr = 1'b0;
    do_reset();
  endtask

  task automatic test_write_read();
    set_op(0, 1'b1, 2'd2, 16'hA5A5);
    run_grants(4'b0001, 1, 1'b0, 1'b0);
    set_op(0, 1'b0, 2'd2, 16'h0000);
    run_grants(4'b0001, 1, 1'b0, 1'b0);
    n_cmp++;
    if (rsp_rdata !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL read_back_hold: rsp_rdata=%h expected a5a5", rsp_rdata);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    obs_q.delete();
    run_grants(4'b1111, 5, 1'b1, 1'b1);
    n_cmp++;
    if (obs_q.size() != 5 || obs_q[0] != 0 || obs_q[1] != 1 || obs_q[2] != 2 || obs_q[3] != 3 || obs_q[4] != 0) begin
      n_bad++;
      $display("FAIL rr_order4: got %p expected '{0,1,2,3,0}", obs_q);
    end
  endtask

  task automatic test_wrap_order();
    run_grants(4'b0010, 1, 1'b0, 1'b1);
    obs_q.delete();
    run_grants(4'b1010, 2, 1'b0, 1'b1);
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[0] != 3 || obs_q[1] != 1) begin
      n_bad++;
      $display("FAIL rr_order_p2: got %p expected '{3,1}", obs_q);
    end
  endtask

  task automatic test_write_ack();
    set_op(2, 1'b1, 2'd3, 16'hBEEF);
    run_grants(4'b0100, 1, 1'b0, 1'b0);
    n_cmp++;
    if (rsp_valid !== '0 || rsp_rdata !== '0) begin
      n_bad++;
      $display("FAIL ack_pulse: rsp_valid=%b rdata=%h expected 0000 0000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    set_op(0, 1'b1, 2'd1, 16'h0F0F);
    run_grants(4'b0001, 1, 1'b0, 1'b0);
    set_op(0, 1'b1, 2'd1, 16'h1234);
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL abort_grant: req_ready=%b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (reg_sel !== '0 || reg_wr !== 1'b0 || rsp_valid !== '0) begin
      n_bad++;
      $display("FAIL abort_async: sel=%b wr=%b rsp=%b expected all 0", reg_sel, reg_wr, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== '0 || dbg_state !== IDLE) begin
      n_bad++;
      $display("FAIL abort_no_rsp: rsp_valid=%b state=%0d expected 0000 0", rsp_valid, dbg_state);
    end
    set_op(0, 1'b0, 2'd1, 16'h0000);
    run_grants(4'b0001, 1, 1'b0, 1'b0);
    n_cmp++;
    if (rsp_rdata !== 16'h0F0F) begin
      n_bad++;
      $display("FAIL abort_old_value: rsp_rdata=%h expected 0f0f", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    run_grants(NREQ'(1 << $urandom_range(0, NREQ - 1)), 3, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++)
      run_grants(NREQ'($urandom_range(1, 15)), $urandom_range(1, 7), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_four();
    test_wrap_order();
    test_write_ack();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
